keypad_scan_ctrl: RTL and testbench

- Scan controller for a 4x4 matrix keypad.
- Drives the keypad rows, samples the columns and debounces each scan frame.
- Emits one-cycle per-key press pulses on key_pulse[15:0], which feed the key latch register that the CPU reads and clears.
- Also outputs an encoded code of the lowest newly pressed key, for a simple polled or IRQ path.

---
 rtl/keypad_scan_ctrl_if.sv | 20 ++
 rtl/keypad_scan_ctrl.sv | 120 ++++++++++++
 tb/tb_keypad_scan_ctrl.sv | 186 ++++++++++++++++++
 3 files changed

// File: rtl/keypad_scan_ctrl_if.sv
// Keypad-side and CPU-side signals of the 4x4 keypad scan controller.
// The controller takes the master view; the keypad/CPU model takes the slave view.
interface keypad_scan_ctrl_if;
   logic [3:0]  col_in;
   logic [3:0]  row_out;
   logic [15:0] key_pulse;
   logic        key_valid;
   logic [3:0]  key_code;
   logic [15:0] key_state;

   modport master (
      input  col_in,
      output row_out, key_pulse, key_valid, key_code, key_state
   );

   modport slave (
      output col_in,
      input  row_out, key_pulse, key_valid, key_code, key_state
   );
endinterface

// File: rtl/keypad_scan_ctrl.sv
// 4x4 matrix keypad scanner: drives rows, samples synchronized columns into a frame
// snapshot, debounces whole frames and emits one-cycle pulses for newly pressed keys.
module keypad_scan_ctrl #(
   parameter int SCAN_DIV        = 1000,
   parameter int DEBOUNCE_FRAMES = 4
) (
   input  logic                 clk,
   input  logic                 rstn,
   keypad_scan_ctrl_if.master   kp
);

   localparam int         SLOT_W    = $clog2(SCAN_DIV);
   localparam logic [3:0] DEB_LIMIT = 4'(DEBOUNCE_FRAMES);

   typedef enum logic [1:0] {S_DRIVE, S_SAMPLE, S_EVAL} state_t;

   state_t              state, state_next;
   logic [SLOT_W-1:0]   slot_cnt;
   logic [1:0]          row_idx;
   logic [3:0]          row_out;
   logic [3:0]          col_meta, col_sync;
   logic [15:0]         snapshot, prev_snap, key_state;
   logic [3:0]          stable_cnt;
   logic [15:0]         key_pulse;
   logic                key_valid;
   logic [3:0]          key_code;

   logic                slot_last;
   logic [3:0]          cnt_next;
   logic                accept;
   logic [15:0]         pulse_next;
   logic [3:0]          code_next;

   assign slot_last = (slot_cnt == SLOT_W'(SCAN_DIV - 2));

   // NOTE: state and datapath registers use non-blocking assignments so every
   // flop samples the pre-edge values; blocking here would create order-dependent races.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) state <= S_DRIVE;
      else       state <= state_next;
   end

   // NOTE: every output of this block gets a default first, so no path can
   // leave a value unassigned and infer a latch.
   always_comb begin
      state_next = state;
      cnt_next   = stable_cnt;
      accept     = 1'b0;
      pulse_next = '0;
      code_next  = '0;

      case (state)
         S_DRIVE:  if (slot_last) state_next = S_SAMPLE;
         S_SAMPLE: state_next = (row_idx == 2'd3) ? S_EVAL : S_DRIVE;
         S_EVAL:   state_next = S_DRIVE;
         default:  state_next = S_DRIVE;
      endcase

      if (state == S_EVAL) begin
         if (snapshot == prev_snap)
            cnt_next = (stable_cnt >= DEB_LIMIT) ? DEB_LIMIT : stable_cnt + 4'd1;
         else
            cnt_next = 4'd1;
         accept = (cnt_next == DEB_LIMIT) && (snapshot != key_state);
      end

      if (accept) pulse_next = snapshot & ~key_state;

      // Scan downward so the last hit is the lowest index.
      for (int i = 15; i >= 0; i--) begin
         if (pulse_next[i]) code_next = 4'(i);
      end
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         col_meta   <= 4'hF;
         col_sync   <= 4'hF;
         slot_cnt   <= '0;
         row_idx    <= 2'd0;
         row_out    <= 4'b1110;
         snapshot   <= '0;
         prev_snap  <= '0;
         stable_cnt <= '0;
         key_state  <= '0;
         key_pulse  <= '0;
         key_valid  <= 1'b0;
         key_code   <= '0;
      end else begin
         col_meta <= kp.col_in;
         col_sync <= col_meta;

         slot_cnt <= (state == S_DRIVE && !slot_last) ? slot_cnt + 1'b1 : '0;

         if (state == S_SAMPLE) begin
            snapshot[{row_idx, 2'b00} +: 4] <= ~col_sync;
            row_idx <= row_idx + 2'd1;
            row_out <= {row_out[2:0], row_out[3]};
         end

         if (state == S_EVAL) begin
            stable_cnt <= cnt_next;
            prev_snap  <= snapshot;
            if (accept) key_state <= snapshot;
         end

         // Releases only clear key_state; pulse_next carries rising keys alone.
         key_pulse <= pulse_next;
         key_valid <= |pulse_next;
         if (|pulse_next) key_code <= code_next;
      end
   end

   assign kp.row_out   = row_out;
   assign kp.key_pulse = key_pulse;
   assign kp.key_valid = key_valid;
   assign kp.key_code  = key_code;
   assign kp.key_state = key_state;

endmodule

// File: tb/tb_keypad_scan_ctrl.sv
// Directed bench for keypad_scan_ctrl with SCAN_DIV=4, DEBOUNCE_FRAMES=3 (17-clock frames)
// and a behavioural keypad matrix driven from a pressed-key map.
module tb_keypad_scan_ctrl;

   localparam int SCAN_DIV = 4;
   localparam int DEB      = 3;
   localparam int FRAME    = 4 * SCAN_DIV + 1;

   logic        clk = 1'b0;
   logic        rstn = 1'b0;
   logic [15:0] pressed = '0;

   keypad_scan_ctrl_if kp_if ();

   keypad_scan_ctrl #(.SCAN_DIV(SCAN_DIV), .DEBOUNCE_FRAMES(DEB)) dut (
      .clk  (clk),
      .rstn (rstn),
      .kp   (kp_if.master)
   );

   always #5 clk = ~clk;

   function automatic logic [3:0] col_model(input logic [3:0] rows, input logic [15:0] keys);
      logic [3:0] c;
      c = 4'hF;
      for (int r = 0; r < 4; r++)
         for (int k = 0; k < 4; k++)
            if (!rows[r] && keys[r*4+k]) c[k] = 1'b0;
      return c;
   endfunction

   assign kp_if.col_in = col_model(kp_if.row_out, pressed);

   int n_tests = 0;
   int n_fail  = 0;

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
      end
   endtask

   int          cyc = 0;
   int          pulse_cnt = 0;
   int          pulse_cyc = 0;
   logic [15:0] last_pulse = '0;
   logic [3:0]  last_code = '0;

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (rstn && (kp_if.key_valid || kp_if.key_pulse != 16'h0)) begin
         check("valid_coinc", 32'(kp_if.key_valid), 32'(|kp_if.key_pulse));
         pulse_cnt++;
         pulse_cyc  = cyc;
         last_pulse = kp_if.key_pulse;
         last_code  = kp_if.key_code;
      end
   end

   // Returns at the negedge of the first row-0 cycle of a frame (the evaluate cycle).
   task automatic align_frame();
      int n;
      n = 0;
      while (kp_if.row_out !== 4'b0111 && n < 100) begin @(negedge clk); n++; end
      while (kp_if.row_out !== 4'b1110 && n < 100) begin @(negedge clk); n++; end
      check("align_timeout", 32'(n >= 100), 32'd0);
   endtask

   task automatic wait_frames(input int n);
      repeat (n * FRAME) @(negedge clk);
   endtask

   int          c0, p0;
   logic [3:0]  exp_row;

   initial begin
      // Reset state
      repeat (3) @(negedge clk);
      check("rst_row_out",   32'(kp_if.row_out),   32'h0000_000E);
      check("rst_key_state", 32'(kp_if.key_state), 32'h0);
      check("rst_key_pulse", 32'(kp_if.key_pulse), 32'h0);
      check("rst_key_valid", 32'(kp_if.key_valid), 32'h0);
      check("rst_key_code",  32'(kp_if.key_code),  32'h0);
      rstn = 1'b1;

      // 1: idle scanning, row rotation and frame length
      wait_frames(10);
      check("idle_pulses", 32'(pulse_cnt), 32'd0);
      check("idle_state",  32'(kp_if.key_state), 32'h0);
      align_frame();
      for (int i = 0; i < FRAME + 1; i++) begin
         exp_row = (i < 5 || i == FRAME) ? 4'b1110 :
                   (i < 9)  ? 4'b1101 :
                   (i < 13) ? 4'b1011 : 4'b0111;
         check($sformatf("row_seq_%0d", i), 32'(kp_if.row_out), 32'(exp_row));
         @(negedge clk);
      end

      // 2: single key 6, exact debounce latency, then release without pulse
      align_frame();
      c0 = cyc; p0 = pulse_cnt;
      pressed[6] = 1'b1;
      wait_frames(5);
      check("k6_pulse_cnt", 32'(pulse_cnt - p0), 32'd1);
      check("k6_pulse",     32'(last_pulse), 32'h0040);
      check("k6_code",      32'(last_code),  32'd6);
      check("k6_latency",   32'(pulse_cyc - c0), 32'(3 * FRAME + 1));
      check("k6_state",     32'(kp_if.key_state), 32'h0040);
      pressed[6] = 1'b0;
      wait_frames(5);
      check("k6_rel_state", 32'(kp_if.key_state), 32'h0);
      check("k6_rel_pulse", 32'(pulse_cnt - p0), 32'd1);

      // 3: bounce for 5 frames, settles pressed on the 5th
      align_frame();
      c0 = cyc; p0 = pulse_cnt;
      for (int f = 0; f < 5; f++) begin
         pressed[6] = ~pressed[6];
         wait_frames(1);
      end
      check("bounce_quiet", 32'(pulse_cnt - p0), 32'd0);
      wait_frames(4);
      check("bounce_cnt",     32'(pulse_cnt - p0), 32'd1);
      check("bounce_latency", 32'(pulse_cyc - c0), 32'(7 * FRAME + 1));
      check("bounce_pulse",   32'(last_pulse), 32'h0040);
      pressed = '0;
      wait_frames(5);
      check("bounce_rel", 32'(kp_if.key_state), 32'h0);

      // 4: keys 3 and 12 in the same frame
      align_frame();
      p0 = pulse_cnt;
      pressed[3] = 1'b1; pressed[12] = 1'b1;
      wait_frames(5);
      check("dual_cnt",   32'(pulse_cnt - p0), 32'd1);
      check("dual_pulse", 32'(last_pulse), 32'h1008);
      check("dual_code",  32'(last_code),  32'd3);
      check("dual_state", 32'(kp_if.key_state), 32'h1008);
      pressed = '0;
      wait_frames(5);

      // 5: key 0 held, key 15 added
      align_frame();
      p0 = pulse_cnt;
      pressed[0] = 1'b1;
      wait_frames(5);
      check("k0_pulse", 32'(last_pulse), 32'h0001);
      check("k0_code",  32'(last_code),  32'd0);
      pressed[15] = 1'b1;
      wait_frames(5);
      check("k15_cnt",   32'(pulse_cnt - p0), 32'd2);
      check("k15_pulse", 32'(last_pulse), 32'h8000);
      check("k15_code",  32'(last_code),  32'd15);
      check("k15_state", 32'(kp_if.key_state), 32'h8001);
      check("k15_hold_code", 32'(kp_if.key_code), 32'd15);
      pressed = '0;
      wait_frames(5);

      // 6: reset mid-frame while key 5 is stable
      pressed[5] = 1'b1;
      wait_frames(5);
      check("k5_state", 32'(kp_if.key_state), 32'h0020);
      align_frame();
      repeat (7) @(negedge clk);
      rstn = 1'b0;
      #1;
      check("mid_rst_row",   32'(kp_if.row_out),   32'h0000_000E);
      check("mid_rst_state", 32'(kp_if.key_state), 32'h0);
      check("mid_rst_pulse", 32'(kp_if.key_pulse), 32'h0);
      repeat (3) @(negedge clk);
      rstn = 1'b1;
      c0 = cyc; p0 = pulse_cnt;
      wait_frames(5);
      check("k5_again_cnt",     32'(pulse_cnt - p0), 32'd1);
      check("k5_again_pulse",   32'(last_pulse), 32'h0020);
      check("k5_again_code",    32'(last_code),  32'd5);
      check("k5_again_latency", 32'(pulse_cyc - c0), 32'(16 + 2 * FRAME + 1));

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
